// File: rtl/audio_mixer.sv
// Stereo mixer: PSG panning plus a low-passed beeper, saturated to DAC width.
// Three register stages: capture, filter/sum, saturate.
module audio_mixer #(
  parameter int OUT_W  = 10,
  parameter int FILT_K = 3
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce,
  input  logic [7:0]       ch_a,
  input  logic [7:0]       ch_b,
  input  logic [7:0]       ch_c,
  input  logic             ear_out,
  input  logic             mic_out,
  input  logic             tape_in,
  input  logic [1:0]       stereo_mode,
  input  logic             filt_en,
  output logic [OUT_W-1:0] left,
  output logic [OUT_W-1:0] right,
  output logic             out_valid
);

  localparam logic [11:0] MAX12 = 12'((2 ** OUT_W) - 1);

  logic [7:0]  a1, b1, c1;
  logic [1:0]  mode1;
  logic        fen1;
  logic [8:0]  x1;
  logic        v1;

  logic [11:0] y;
  logic [11:0] x8;
  logic [12:0] diff;
  logic [12:0] step;
  logic [12:0] y_sum;
  logic [11:0] y_next;
  logic [10:0] psg_l, psg_r;
  logic [10:0] aa, bb, cc;

  logic [10:0] l2, r2;
  logic [8:0]  beep2;
  logic        v2;

  logic [11:0] sum_l, sum_r;

  function automatic logic [OUT_W-1:0] sat(input logic [11:0] s);
    if (s > MAX12) return {OUT_W{1'b1}};
    return s[OUT_W-1:0];
  endfunction

  // Stage 1: capture one sample per ce; beeper weighted 256/128/64.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      v1 <= 1'b0;
    end else begin
      v1 <= ce;
    end
    if (ce) begin
      a1    <= ch_a;
      b1    <= ch_b;
      c1    <= ch_c;
      mode1 <= stereo_mode;
      fen1  <= filt_en;
      x1    <= {ear_out, mic_out, tape_in, 6'b0};
    end
  end

  // Beeper one-pole low-pass (9.3 fixed point) and PSG panning.
  always_comb begin
    x8     = {x1, 3'b000};
    diff   = $signed({1'b0, x8}) - $signed({1'b0, y});
    step   = $signed(diff) >>> FILT_K;
    y_sum  = {1'b0, y} + step;
    y_next = fen1 ? y_sum[11:0] : x8;
    aa     = {3'b000, a1};
    bb     = {3'b000, b1};
    cc     = {3'b000, c1};
    psg_l  = (aa << 1) + bb;
    psg_r  = (cc << 1) + bb;
    unique case (1'b1)
      (mode1 == 2'b01): begin
        psg_l = (aa << 1) + cc;
        psg_r = (bb << 1) + cc;
      end
      (mode1 == 2'b10): begin
        psg_l = aa + bb + cc;
        psg_r = aa + bb + cc;
      end
      default: begin
        psg_l = (aa << 1) + bb;
        psg_r = (cc << 1) + bb;
      end
    endcase
  end

  // Stage 2: advance filter state and hold the channel sums.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      v2 <= 1'b0;
      y  <= '0;
    end else begin
      v2 <= v1;
      if (v1) y <= y_next;
    end
    if (v1) begin
      l2    <= psg_l;
      r2    <= psg_r;
      beep2 <= y_next[11:3];
    end
  end

  // Stage 3 mix: 12-bit sum cannot overflow (max 1213).
  always_comb begin
    sum_l = {1'b0, l2} + {3'b000, beep2};
    sum_r = {1'b0, r2} + {3'b000, beep2};
  end

  // Stage 3: clamp to DAC range and strobe out_valid.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      left      <= '0;
      right     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        left  <= sat(sum_l);
        right <= sat(sum_r);
      end
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer: latency, filter steps, panning,
// saturation, streaming and reset flush.
module tb_audio_mixer;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ce;
  logic [7:0] ch_a, ch_b, ch_c;
  logic       ear_out, mic_out, tape_in;
  logic [1:0] stereo_mode;
  logic       filt_en;
  logic [9:0] left, right;
  logic       out_valid;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] va [8];
  logic [7:0] vb [8];
  logic [7:0] vc [8];
  logic [2:0] vbp[8];
  logic [1:0] vm [8];
  logic       vf [8];
  int         el [8];
  int         er [8];

  audio_mixer #(.OUT_W(10), .FILT_K(3)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce         (ce),
    .ch_a       (ch_a),
    .ch_b       (ch_b),
    .ch_c       (ch_c),
    .ear_out    (ear_out),
    .mic_out    (mic_out),
    .tape_in    (tape_in),
    .stereo_mode(stereo_mode),
    .filt_en    (filt_en),
    .left       (left),
    .right      (right),
    .out_valid  (out_valid)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int i, input int a, input int b,
                         input int c, input logic [2:0] bp,
                         input logic [1:0] m, input logic f,
                         input int l, input int r);
    va[i]  = 8'(a);
    vb[i]  = 8'(b);
    vc[i]  = 8'(c);
    vbp[i] = bp;
    vm[i]  = m;
    vf[i]  = f;
    el[i]  = l;
    er[i]  = r;
  endtask

  // Back-to-back ce for n samples; sample i appears at negedge i+3.
  task automatic run(input int n, input string tag);
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk_sys);
      if (i >= 3) begin
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_left"},  int'(left),  el[i-3]);
        chk({tag, "_right"}, int'(right), er[i-3]);
      end else begin
        chk({tag, "_idle"}, int'(out_valid), 0);
      end
      if (i < n) begin
        ce          = 1'b1;
        ch_a        = va[i];
        ch_b        = vb[i];
        ch_c        = vc[i];
        {ear_out, mic_out, tape_in} = vbp[i];
        stereo_mode = vm[i];
        filt_en     = vf[i];
      end else begin
        ce = 1'b0;
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    ce          = 1'b0;
    ch_a        = '0;
    ch_b        = '0;
    ch_c        = '0;
    ear_out     = 1'b0;
    mic_out     = 1'b0;
    tape_in     = 1'b0;
    stereo_mode = 2'b00;
    filt_en     = 1'b0;

    repeat (2) @(negedge clk_sys);
    chk("rst_left",  int'(left), 0);
    chk("rst_right", int'(right), 0);
    chk("rst_valid", int'(out_valid), 0);
    ce = 1'b1;
    ear_out = 1'b1;
    @(negedge clk_sys);
    chk("rst_ce_valid", int'(out_valid), 0);
    ce = 1'b0;
    ear_out = 1'b0;
    reset = 1'b0;

    // single sample, ear only, unfiltered
    set_vec(0, 0, 0, 0, 3'b100, 2'b00, 1'b0, 256, 256);
    run(1, "single");

    @(negedge clk_sys);
    chk("single_tail", int'(out_valid), 0);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;

    // filter step 0->448 then decay to 0
    set_vec(0, 0, 0, 0, 3'b111, 2'b00, 1'b1, 56, 56);
    set_vec(1, 0, 0, 0, 3'b111, 2'b00, 1'b1, 105, 105);
    set_vec(2, 0, 0, 0, 3'b111, 2'b00, 1'b1, 147, 147);
    set_vec(3, 0, 0, 0, 3'b111, 2'b00, 1'b1, 185, 185);
    set_vec(4, 0, 0, 0, 3'b000, 2'b00, 1'b1, 162, 162);
    set_vec(5, 0, 0, 0, 3'b000, 2'b00, 1'b1, 141, 141);
    set_vec(6, 0, 0, 0, 3'b000, 2'b00, 1'b1, 124, 124);
    run(7, "filt");

    // panning modes switched between consecutive samples
    set_vec(0, 100, 10, 50, 3'b000, 2'b00, 1'b0, 210, 110);
    set_vec(1, 100, 10, 50, 3'b000, 2'b01, 1'b0, 250, 70);
    set_vec(2, 100, 10, 50, 3'b000, 2'b10, 1'b0, 160, 160);
    run(3, "mode");

    // full PSG plus full beeper clamps
    set_vec(0, 255, 255, 255, 3'b111, 2'b00, 1'b0, 1023, 1023);
    run(1, "sat");

    // eight-sample stream
    set_vec(0, 1, 2, 3, 3'b000, 2'b00, 1'b0, 4, 8);
    set_vec(1, 10, 20, 30, 3'b100, 2'b01, 1'b0, 306, 326);
    set_vec(2, 5, 5, 5, 3'b010, 2'b10, 1'b0, 143, 143);
    set_vec(3, 200, 100, 50, 3'b001, 2'b00, 1'b0, 564, 264);
    set_vec(4, 255, 255, 255, 3'b111, 2'b10, 1'b0, 1023, 1023);
    set_vec(5, 0, 0, 0, 3'b000, 2'b11, 1'b0, 0, 0);
    set_vec(6, 7, 0, 9, 3'b110, 2'b11, 1'b0, 398, 402);
    set_vec(7, 128, 64, 32, 3'b011, 2'b01, 1'b0, 480, 352);
    run(8, "stream");

    // reset one clock after a ce flushes the sample
    @(negedge clk_sys);
    ce      = 1'b1;
    ear_out = 1'b1;
    filt_en = 1'b1;
    ch_a    = 8'd40;
    @(negedge clk_sys);
    ce    = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("flush_valid0", int'(out_valid), 0);
    chk("flush_left",   int'(left), 0);
    chk("flush_right",  int'(right), 0);
    @(negedge clk_sys);
    chk("flush_valid1", int'(out_valid), 0);
    @(negedge clk_sys);
    chk("flush_valid2", int'(out_valid), 0);

    // filter restarts from zero: 2048/8 = 256 -> integer 32
    set_vec(0, 0, 0, 0, 3'b100, 2'b00, 1'b1, 32, 32);
    run(1, "post_rst");
    @(negedge clk_sys);
    chk("post_rst_tail", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
